// File: rtl/seg_disp_pkg.sv
// Shared constants for the multiplexed 7-segment display scheduler.
package seg_disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [1:0]  SRC_NONE   = 2'b00;
    localparam logic [1:0]  SRC_A      = 2'b01;
    localparam logic [1:0]  SRC_B      = 2'b10;
    localparam logic [3:0]  AN_ALL_OFF = 4'hF;

endpackage

// File: rtl/scan_prescaler.sv
// Clock-enable prescaler: one-cycle tick every SCAN_DIV system clocks.
module scan_prescaler #(
    parameter int unsigned SCAN_DIV = 262144
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        tick    = (presc_q == LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Digit scan, frame-boundary source arbitration with minimum dwell, and
// leading-zero blanking for a 4-digit multiplexed 7-segment display.
module seg_display_scheduler
    import seg_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 262144,
    parameter int unsigned MIN_FRAMES = 8,
    parameter int unsigned DIGIT_W    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            a_valid,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   a_data,
    output logic                            a_ready,
    input  logic                            b_valid,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   b_data,
    output logic                            b_ready,
    input  logic                            blank_lz,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [DIGIT_W-1:0]              digit,
    output logic                            digit_blank,
    output logic                            frame_done,
    output logic [1:0]                      src
);

    localparam int unsigned WW = NUM_DIGITS * DIGIT_W;
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned DW = (MIN_FRAMES > 1) ? $clog2(MIN_FRAMES) : 1;

    logic          tick;
    logic [IW-1:0] idx_q,    idx_d;
    logic [3:0]    an_q,     an_d;
    logic [WW-1:0] shadow_q, shadow_d;
    logic [1:0]    src_q,    src_d;
    logic [DW-1:0] dwell_q,  dwell_d;
    logic [DW-1:0] dwell_dec;
    logic [1:0]    grant;
    logic          owner_valid;
    logic          lz_zero;

    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Arbitration: a dwelling owner that still offers data keeps the display.
    always_comb begin
        frame_done  = tick && (idx_q == IW'(NUM_DIGITS - 1));
        owner_valid = ((src_q == SRC_A) && a_valid) || ((src_q == SRC_B) && b_valid);
        grant       = SRC_NONE;
        if ((dwell_q != '0) && owner_valid) begin
            grant = src_q;
        end else if (a_valid) begin
            grant = SRC_A;
        end else if (b_valid) begin
            grant = SRC_B;
        end
        a_ready   = frame_done && (grant == SRC_A);
        b_ready   = frame_done && (grant == SRC_B);
        dwell_dec = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
    end

    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        src_d    = src_q;
        dwell_d  = dwell_q;
        if (tick) begin
            idx_d = idx_q + IW'(1);
        end
        if (frame_done) begin
            dwell_d = dwell_dec;
            if (a_ready || b_ready) begin
                shadow_d = a_ready ? a_data : b_data;
                src_d    = grant;
                if (grant != src_q) begin
                    dwell_d = DW'(MIN_FRAMES - 1);
                end
            end
        end
        an_d = AN_ALL_OFF ^ (4'(1) << idx_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= '0;
            an_q     <= 4'b1110;
            shadow_q <= '0;
            src_q    <= SRC_NONE;
            dwell_q  <= '0;
        end else begin
            idx_q    <= idx_d;
            an_q     <= an_d;
            shadow_q <= shadow_d;
            src_q    <= src_d;
            dwell_q  <= dwell_d;
        end
    end

    // Leading-zero test: selected digit and every digit to its left are zero.
    always_comb begin
        lz_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IW'(i) >= idx_q) && (shadow_q[i*DIGIT_W +: DIGIT_W] != '0)) begin
                lz_zero = 1'b0;
            end
        end
        digit       = shadow_q[idx_q*DIGIT_W +: DIGIT_W];
        digit_blank = (src_q == SRC_NONE) || (blank_lz && (idx_q != '0) && lz_zero);
    end

    assign an  = an_q;
    assign src = src_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: cycle-level model compare plus directed literal checks.
module tb_seg_display_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [15:0] a_data = 16'h0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [15:0] b_data = 16'h0;
    logic        b_ready;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        digit_blank;
    logic        frame_done;
    logic [1:0]  src;

    int checks = 0;
    int failures = 0;
    int t = 0;

    seg_display_scheduler #(.SCAN_DIV(4), .MIN_FRAMES(2), .DIGIT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .blank_lz    (blank_lz),
        .an          (an),
        .digit       (digit),
        .digit_blank (digit_blank),
        .frame_done  (frame_done),
        .src         (src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, got, exp);
        end
    endtask

    // Behavioural model: frame position from cycle count, owner/dwell/word as plain state.
    int          m_cyc = 0;
    logic [15:0] m_word = 16'h0;
    int          m_src = 0;
    int          m_dwell = 0;
    bit          m_on = 0;

    always @(negedge clk) begin : model
        int          slot;
        bit          fd;
        int          g;
        logic [3:0]  e_an;
        logic [15:0] rest;
        bit          e_blank;
        slot = (m_cyc / 4) % 4;
        fd   = (m_cyc % 16) == 15;
        if (m_dwell > 0 && ((m_src == 1 && a_valid) || (m_src == 2 && b_valid))) g = m_src;
        else if (a_valid) g = 1;
        else if (b_valid) g = 2;
        else g = 0;
        if (m_on) begin
            e_an = 4'b1111;
            e_an[slot] = 1'b0;
            rest = m_word >> (4 * slot);
            e_blank = (m_src == 0) || (blank_lz && slot != 0 && rest == 16'h0);
            chk("m_an", 32'(an), 32'(e_an));
            chk("m_digit", 32'(digit), 32'(rest & 16'hF));
            chk("m_blank", 32'(digit_blank), 32'(e_blank));
            chk("m_frame_done", 32'(frame_done), 32'(fd));
            chk("m_a_ready", 32'(a_ready), 32'(fd && g == 1));
            chk("m_b_ready", 32'(b_ready), 32'(fd && g == 2));
            chk("m_src", 32'(src), 32'(m_src));
        end
        if (reset) begin
            m_cyc = 0; m_word = 16'h0; m_src = 0; m_dwell = 0; m_on = 1;
        end else if (m_on) begin
            if (fd) begin
                if (g != 0) begin
                    m_dwell = (g != m_src) ? 1 : (m_dwell > 0 ? m_dwell - 1 : 0);
                    m_word  = (g == 1) ? a_data : b_data;
                    m_src   = g;
                end else begin
                    m_dwell = m_dwell > 0 ? m_dwell - 1 : 0;
                end
            end
            m_cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic goto(input int n);
        while (t < n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset state and free-running scan
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        t = 0;
        chk("rst_an", 32'(an), 32'hE);
        chk("rst_src", 32'(src), 32'h0);
        chk("rst_blank", 32'(digit_blank), 32'h1);
        chk("rst_digit", 32'(digit), 32'h0);
        goto(4);  chk("scan_an1", 32'(an), 32'hD);
        goto(8);  chk("scan_an2", 32'(an), 32'hB);
        goto(12); chk("scan_an3", 32'(an), 32'h7);
        goto(15); chk("fd15", 32'(frame_done), 32'h1);
        goto(16); chk("fd16", 32'(frame_done), 32'h0);

        // 2: A offers 1234
        goto(20); a_valid = 1'b1; a_data = 16'h1234;
        goto(30); chk("a_rdy_early", 32'(a_ready), 32'h0);
        goto(31); chk("a_rdy_fd", 32'(a_ready), 32'h1);
        goto(32); chk("d0_4", 32'(digit), 32'h4); chk("src_a", 32'(src), 32'h1);
        goto(36); chk("d1_3", 32'(digit), 32'h3);
        goto(40); chk("d2_2", 32'(digit), 32'h2);
        goto(44); chk("d3_1", 32'(digit), 32'h1); chk("an_d3", 32'(an), 32'h7);

        // 3: both valid, A wins; A drops, B loads
        goto(50); b_valid = 1'b1; b_data = 16'h5678;
        goto(63); chk("both_a", 32'(a_ready), 32'h1); chk("both_b", 32'(b_ready), 32'h0);
        goto(64); a_valid = 1'b0;
        goto(79); chk("b_load", 32'(b_ready), 32'h1);
        goto(80); chk("src_b", 32'(src), 32'h2); chk("b_d0", 32'(digit), 32'h8);

        // 4: B dwelling holds off A one frame
        goto(81); a_valid = 1'b1; a_data = 16'h9999;
        goto(95); chk("dwell_a", 32'(a_ready), 32'h0); chk("dwell_b", 32'(b_ready), 32'h1);
        goto(111); chk("a_takes", 32'(a_ready), 32'h1);
        goto(112); chk("src_a2", 32'(src), 32'h1); chk("d_9", 32'(digit), 32'h9);
        b_valid = 1'b0;

        // 5: leading-zero blanking
        blank_lz = 1'b1; a_data = 16'h0070;
        goto(128); chk("lz0_d", 32'(digit), 32'h0); chk("lz0_b", 32'(digit_blank), 32'h0);
        goto(132); chk("lz1_d", 32'(digit), 32'h7); chk("lz1_b", 32'(digit_blank), 32'h0);
        goto(136); chk("lz2_b", 32'(digit_blank), 32'h1);
        goto(140); chk("lz3_b", 32'(digit_blank), 32'h1);
        goto(141); a_data = 16'h0000;
        goto(144); chk("z0_b", 32'(digit_blank), 32'h0); chk("z0_d", 32'(digit), 32'h0);
        goto(148); chk("z1_b", 32'(digit_blank), 32'h1);
        goto(152); chk("z2_b", 32'(digit_blank), 32'h1);
        goto(156); chk("z3_b", 32'(digit_blank), 32'h1);

        // 6: reset mid-frame with A still valid
        goto(158); reset = 1'b1; a_data = 16'h4321;
        step();
        reset = 1'b0;
        t = 0;
        chk("r6_an", 32'(an), 32'hE);
        chk("r6_src", 32'(src), 32'h0);
        chk("r6_digit", 32'(digit), 32'h0);
        chk("r6_blank", 32'(digit_blank), 32'h1);
        for (int i = 0; i < 15; i++) begin
            chk("r6_no_rdy", 32'(a_ready), 32'h0);
            step();
        end
        chk("r6_rdy15", 32'(a_ready), 32'h1);
        goto(16); chk("r6_src_a", 32'(src), 32'h1); chk("r6_d0", 32'(digit), 32'h1);
        goto(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
